// File: rtl/upsample_interp_pkg.sv
// Shared definitions for the interpolating upsampler: fill-mode encodings
// and the upsample factor derived from its log2.
package upsample_pkg;

  typedef enum logic [1:0] {
    MODE_ZERO = 2'd0,
    MODE_HOLD = 2'd1,
    MODE_LIN  = 2'd2
  } mode_e;

  function automatic int unsigned upsample_factor(input int unsigned log2_factor);
    return 32'd1 << log2_factor;
  endfunction

endpackage

// File: rtl/upsample_interp_calc.sv
// Combinational output-sample generator: maps (prev, cur, phase, mode) to
// one output sample. Mode 3 is unassigned and falls through to hold.
module interp_calc
  import upsample_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int LOG2_FACTOR = 2
) (
  input  logic signed [DATA_W-1:0]      prev,
  input  logic signed [DATA_W-1:0]      cur,
  input  logic        [LOG2_FACTOR-1:0] k,
  input  logic        [1:0]             mode_q,
  output logic        [DATA_W-1:0]      out_data
);

  localparam int PW = DATA_W + LOG2_FACTOR + 2;

  logic signed [DATA_W:0]      diff;
  logic        [LOG2_FACTOR:0] kp1;
  logic signed [PW-1:0]        diff_ext;
  logic signed [PW-1:0]        kp1_ext;
  logic signed [PW-1:0]        prod;
  logic signed [PW-1:0]        step;
  logic        [DATA_W-1:0]    lin;

  // Linear ramp: prev + floor((cur-prev)*(k+1)/F). The step magnitude never
  // exceeds |cur-prev|, so the DATA_W-bit sum cannot leave [prev, cur].
  always_comb begin
    diff     = {cur[DATA_W-1], cur} - {prev[DATA_W-1], prev};
    kp1      = {1'b0, k} + (LOG2_FACTOR + 1)'(1);
    diff_ext = {{(LOG2_FACTOR + 1){diff[DATA_W]}}, diff};
    kp1_ext  = {{(DATA_W + 1){1'b0}}, kp1};
    prod     = diff_ext * kp1_ext;
    step     = prod >>> LOG2_FACTOR;
    lin      = prev + step[DATA_W-1:0];
  end

  // Select the fill rule for the current phase.
  always_comb begin
    out_data = cur;
    case (mode_q)
      MODE_ZERO: out_data = (k == '0) ? cur : '0;
      MODE_LIN:  out_data = lin;
      default:   out_data = cur;
    endcase
  end

endmodule

// File: rtl/upsample_interp.sv
// Interpolating upsampler: one signed sample in per input handshake,
// 2**LOG2_FACTOR samples out, valid/ready on both sides.
module upsample_interp
  import upsample_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int LOG2_FACTOR = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam int unsigned                F          = upsample_factor(LOG2_FACTOR);
  localparam logic [LOG2_FACTOR-1:0]     LAST_PHASE = LOG2_FACTOR'(F - 1);

  logic signed [DATA_W-1:0]      cur_q, cur_d;
  logic signed [DATA_W-1:0]      prev_q, prev_d;
  logic        [LOG2_FACTOR-1:0] phase_q, phase_d;
  mode_e                         mode_q_q, mode_q_d;
  logic                          out_valid_q, out_valid_d;

  logic in_acc;
  logic out_acc;

  // in_ready looks at out_ready combinationally so the last output of one
  // burst and the next input accept share a cycle, keeping bursts gapless.
  always_comb begin
    in_ready = !out_valid_q || ((phase_q == LAST_PHASE) && out_ready);
    in_acc   = in_valid && in_ready;
    out_acc  = out_valid_q && out_ready;
  end

  // Next-state: an input accept takes priority over finishing a burst.
  always_comb begin
    cur_d       = cur_q;
    prev_d      = prev_q;
    phase_d     = phase_q;
    mode_q_d    = mode_q_q;
    out_valid_d = out_valid_q;
    if (in_acc) begin
      prev_d      = cur_q;
      cur_d       = in_data;
      mode_q_d    = mode_e'(mode);
      phase_d     = '0;
      out_valid_d = 1'b1;
    end else if (out_acc) begin
      if (phase_q == LAST_PHASE) begin
        phase_d     = '0;
        out_valid_d = 1'b0;
      end else begin
        phase_d = phase_q + LOG2_FACTOR'(1);
      end
    end
  end

  // State registers with synchronous reset clearing history too.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q       <= '0;
      prev_q      <= '0;
      phase_q     <= '0;
      mode_q_q    <= MODE_ZERO;
      out_valid_q <= 1'b0;
    end else begin
      cur_q       <= cur_d;
      prev_q      <= prev_d;
      phase_q     <= phase_d;
      mode_q_q    <= mode_q_d;
      out_valid_q <= out_valid_d;
    end
  end

  interp_calc #(
    .DATA_W      (DATA_W),
    .LOG2_FACTOR (LOG2_FACTOR)
  ) u_calc (
    .prev     (prev_q),
    .cur      (cur_q),
    .k        (phase_q),
    .mode_q   (mode_q_q),
    .out_data (out_data)
  );

  assign out_valid = out_valid_q;
  assign busy      = out_valid_q;

endmodule

// File: tb/tb_upsample_interp.sv
// Self-checking bench for upsample_interp: a queue-based reference model of
// the expected output stream, checked every cycle, plus directed literals.
module tb_upsample_interp;

  localparam int DW = 16;
  localparam int LF = 2;
  localparam int F  = 1 << LF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          busy;

  upsample_interp #(
    .DATA_W      (DW),
    .LOG2_FACTOR (LF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int armed = 0;
  int cyc   = 0;

  int exp_q[$];
  int log_v[$];
  int log_c[$];
  int want[$];
  int m_prev = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Output sample k of a burst for sample x following history p.
  function automatic int model_val(input int md, input int p, input int x, input int k);
    int num, q;
    case (md)
      0: return (k == 0) ? x : 0;
      2: begin
        num = (x - p) * (k + 1);
        q   = num / F;
        if ((num % F) != 0 && num < 0) q = q - 1;
        return p + q;
      end
      default: return x;
    endcase
  endfunction

  // Per-cycle compare against the model, then advance the model.
  always @(negedge clk) begin
    int  x;
    bit  ev, er;
    cyc++;
    if (armed != 0) begin
      ev = (exp_q.size() != 0);
      er = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
      chk("out_valid", int'(out_valid), int'(ev));
      chk("busy", int'(busy), int'(ev));
      chk("in_ready", int'(in_ready), int'(er));
      if (ev) chk("out_data", int'($signed(out_data)), exp_q[0]);
      if (rst) begin
        exp_q.delete();
        m_prev = 0;
      end else begin
        if (ev && out_ready) begin
          log_v.push_back(int'($signed(out_data)));
          log_c.push_back(cyc);
          void'(exp_q.pop_front());
        end
        if (in_valid && er) begin
          x = int'($signed(in_data));
          for (int k = 0; k < F; k++) exp_q.push_back(model_val(int'(mode), m_prev, x, k));
          m_prev = x;
        end
      end
    end else if (rst) begin
      exp_q.delete();
      m_prev = 0;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send(input int v, input logic [1:0] md);
    bit ok;
    ok       = 0;
    in_data  = DW'(v);
    mode     = md;
    in_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!out_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic chk_want(input string nm, input int base);
    if (log_v.size() < base + want.size()) begin
      chk({nm, "_count"}, log_v.size() - base, want.size());
    end else begin
      for (int i = 0; i < want.size(); i++) chk(nm, log_v[base + i], want[i]);
    end
  endtask

  initial begin
    int base;
    int r;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    armed = 1;

    // reset state
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_data", int'($signed(out_data)), 0);
    @(posedge clk); #1;

    // 1: zero-insert, back-to-back, no gap
    base = log_v.size();
    send(100, 2'd0);
    send(-8, 2'd0);
    drain();
    want = '{100, 0, 0, 0, -8, 0, 0, 0};
    chk_want("zero_seq", base);
    if (log_c.size() >= base + 8) chk("zero_nogap", log_c[base + 7] - log_c[base], 7);

    // 2: linear from reset
    do_reset();
    base = log_v.size();
    send(100, 2'd2);
    send(20, 2'd2);
    drain();
    want = '{25, 50, 75, 100, 80, 60, 40, 20};
    chk_want("lin_seq", base);

    // 3: floor rounding toward -inf
    do_reset();
    base = log_v.size();
    send(-3, 2'd2);
    drain();
    want = '{-1, -2, -3, -3};
    chk_want("lin_floor", base);

    // 4: full-scale swing
    do_reset();
    send(-32768, 2'd2);
    drain();
    base = log_v.size();
    send(32767, 2'd2);
    drain();
    want = '{-16385, -1, 16383, 32767};
    chk_want("lin_swing", base);

    // 5: backpressure at phase 2 of a hold burst
    send(7, 2'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    base = log_v.size();
    repeat (5) begin
      @(negedge clk);
      chk("bp_data", int'($signed(out_data)), 7);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_valid", int'(out_valid), 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();
    chk("bp_remaining", log_v.size() - base, 2);

    // 6: reset mid-burst
    send(60, 2'd2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_busy", int'(busy), 0);
    @(posedge clk); #1;
    base = log_v.size();
    send(40, 2'd2);
    drain();
    want = '{10, 20, 30, 40};
    chk_want("midrst_lin", base);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 299) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      r        = $urandom_range(0, 9);
      if (r == 0)      in_data = 16'h8000;
      else if (r == 1) in_data = 16'h7fff;
      else             in_data = 16'($urandom);
      mode      = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/upsample_interp.md
Name: upsample_interp

Overview:
- Interpolating upsampler, the reverse direction of the team's downsampling datapath.
- Accepts one signed sample per input handshake and emits 2**LOG2_FACTOR output samples per input.
- Three fill modes: zero-insert, sample-hold, linear interpolation.
- Sits ahead of reconstruction or DAC-side logic; valid/ready on both sides.

Parameters:
DATA_W, 16, sample width (signed two's complement)
LOG2_FACTOR, 2, log2 of upsample factor F (F = 4 at default); legal range 1..4

Ports:
clk  input  1  system clock, all logic rising-edge
rst  input  1  synchronous, active-high reset
mode  input  2  fill mode: 0 zero-insert, 1 hold, 2 linear, 3 reserved (behaves as hold)
in_data  input  DATA_W  signed input sample
in_valid  input  1  input sample present
in_ready  output  1  block can accept a sample this cycle
out_data  output  DATA_W  signed output sample
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data this cycle
busy  output  1  equals out_valid

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- State registers: cur, prev (DATA_W, signed), phase (LOG2_FACTOR bits), mode_q (2), out_valid.
- Reset values: cur=0, prev=0, phase=0, mode_q=0, out_valid=0.
  - Consequences: out_data=0, in_ready=1, busy=0.
- Handshakes:
  - Input accept: in_valid && in_ready.
  - Output accept: out_valid && out_ready.
- in_ready = !out_valid || (phase==F-1 && out_ready).
  - Combinational from out_ready, so back-to-back bursts run at full output rate: one input per F cycles, no bubble.
- On input accept: prev<=cur, cur<=in_data, mode_q<=mode, phase<=0, out_valid<=1.
  - Output latency: first output valid the cycle after accept.
- On output accept without input accept:
  - phase<F-1: phase<=phase+1.
  - phase==F-1: out_valid<=0, phase<=0.
- Simultaneous accepts at the last phase: the input-accept action wins; out_valid stays 1.
- out_valid && !out_ready: all registers hold, so out_data is stable. in_valid is ignored while in_ready=0.
- mode is sampled only at input accept. A mode change mid-burst affects the next burst only.
- out_data is combinational from the registers, with k=phase:
  - zero-insert: k==0 ? cur : 0.
  - hold: cur.
  - linear: prev + (((cur-prev)*(k+1)) >>> LOG2_FACTOR).
    - Difference is DATA_W+1 bits signed; product is DATA_W+LOG2_FACTOR+2 bits signed.
    - The shift is an arithmetic right shift (floor toward -inf).
    - The result always lies between prev and cur, so truncation to DATA_W is lossless. No saturation logic.
    - k=F-1 yields exactly cur. Linear output lags input by one sample period by construction.
- History: prev is the previous accepted sample, or 0 after reset. The first linear burst after reset ramps from 0.
- Reset mid-burst: the burst is dropped and history is cleared. No partial output appears after rst deasserts.
- Mode 3: identical to hold.

Decomposition:
- Package upsample_pkg holds:
  - mode encodings: MODE_ZERO=0, MODE_HOLD=1, MODE_LIN=2.
  - a function for F from LOG2_FACTOR.
- Sub-module interp_calc (purely combinational): prev, cur, k, mode_q -> out_data. Isolates the arithmetic for unit testing.
- Control (handshake, phase counter, registers) stays in upsample_interp.

Test Plan:
1. Zero-insert, F=4, out_ready=1, inputs 100 then -8 back-to-back -> out_data 100,0,0,0,-8,0,0,0 on consecutive cycles; in_ready high only on cycles 0 and 4 of each burst; no gap in out_valid.
2. Linear from reset, inputs 100 then 20 -> 25,50,75,100, then 80,60,40,20.
3. Linear floor rounding, from reset, input -3 -> -1,-2,-3,-3.
4. Extreme swing, linear: prev=-32768, then input 32767 -> -16385,-1,16383,32767; no overflow.
5. Backpressure: out_ready low for 5 cycles at phase 2 of a hold burst of value 7 -> out_data stays 7, phase stays 2, in_ready=0 throughout; burst resumes with exactly 2 more outputs.
6. Reset mid-burst: assert rst at phase 1 of a linear burst -> next cycle out_valid=0, in_ready=1, busy=0; a subsequent linear input 40 -> 10,20,30,40.
